seq_multiply: RTL and testbench

- Iterative shift-add multiplier for the mini CPU execute stage; the multiply counterpart to the divide unit.
- Takes two WIDTH-bit operands and produces a 2*WIDTH-bit product, one multiplier bit per clock.
- Uses a start/busy/done handshake so the control FSM can stall while the multiply runs.

---
 rtl/mini_cpu_pkg.sv | 17 +
 rtl/negate_wide.sv | 12 +
 rtl/seq_multiply.sv | 143 ++++++++++++++
 tb/tb_seq_multiply.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU execute-stage arithmetic units:
// multiplier FSM state encoding, default operand width and product width.
package mini_cpu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/negate_wide.sv
// Two's-complement negator of configurable width; used for signed operand
// magnitudes and for the signed product.
module negate_wide #(
  parameter int W = 64
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] negated
);

  assign negated = (~value) + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/seq_multiply.sv
// Iterative shift-add multiplier, one multiplier bit per clock, start/busy/done
// handshake. Optional two's-complement operation when MULTIPLY_SIGNED_EN is defined.
//
// Handshake: start is accepted on any rising edge where the unit is in IDLE or
// DONE; A/B/signed_op are sampled on that edge only. busy is high for exactly
// WIDTH cycles, then done pulses for one cycle with product valid; product then
// holds until the next accepted start.
module seq_multiply
  import mini_cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          signed_op,
  input  logic [WIDTH-1:0]              A,
  input  logic [WIDTH-1:0]              B,
  output logic                          busy,
  output logic                          done,
  output logic [prod_width(WIDTH)-1:0]  product
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  mul_state_t       state;
  mul_state_t       state_next;
  logic             accept;
  logic             finish;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    count;
  logic [PW-1:0]    product_r;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] b_load;

  // Keep the carry of hi + multiplicand, then shift {carry, hi, lo} right.
  assign sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign step_hi = sum[WIDTH:1];
  assign step_lo = {sum[0], acc_lo[WIDTH-1:1]};

`ifdef MULTIPLY_SIGNED_EN
  logic             neg;
  logic             neg_load;
  logic [WIDTH-1:0] a_neg;
  logic [WIDTH-1:0] b_neg;
  logic [PW-1:0]    acc_neg;

  negate_wide #(.W(WIDTH)) u_neg_a   (.value(A), .negated(a_neg));
  negate_wide #(.W(WIDTH)) u_neg_b   (.value(B), .negated(b_neg));
  negate_wide #(.W(PW))    u_neg_acc (.value({step_hi, step_lo}), .negated(acc_neg));

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign a_load   = (signed_op && A[WIDTH-1]) ? a_neg : A;
  assign b_load   = (signed_op && B[WIDTH-1]) ? b_neg : B;
  assign neg_load = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
  assign result   = neg ? acc_neg : {step_hi, step_lo};
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign a_load = A;
  assign b_load = B;
  assign result = {step_hi, step_lo};
`endif

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (count == LAST_COUNT) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      count     <= '0;
      product_r <= '0;
`ifdef MULTIPLY_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        mcand  <= a_load;
        acc_hi <= '0;
        acc_lo <= b_load;
        count  <= '0;
`ifdef MULTIPLY_SIGNED_EN
        neg    <= neg_load;
`endif
      end else if (state == ST_RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        count  <= count + CW'(1);
        if (finish) begin
          product_r <= result;
        end
      end
    end
  end

  assign product = product_r;

endmodule

// File: tb/tb_seq_multiply.sv
// Self-checking bench for seq_multiply: directed cases plus random operands,
// compared against an arithmetic reference model.
module tb_seq_multiply;

  localparam int W  = 32;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          signed_op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_product;

  seq_multiply #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .A(A), .B(B), .busy(busy), .done(done), .product(product)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
`ifdef MULTIPLY_SIGNED_EN
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
`endif
    sa = {{W{1'b0}}, a};
    sb = {{W{1'b0}}, b};
    return (sa * sb) + PW'(0 * s);
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: present one request; 'now' means we are already at a negedge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit now);
    if (!now) @(negedge clk);
    A = a;
    B = b;
    signed_op = s;
    start = 1'b1;
    exp_q.push_back(ref_mul(a, b, s));
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    signed_op = 1'($urandom_range(0, 1));
  endtask

  // Waits for done after an accepted start; optionally fires a start while busy.
  task automatic wait_done(input string tag, input bit inject);
    int            lat = 0;
    int            busy_cycles = 0;
    bit            seen = 0;
    logic [PW-1:0] exp;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
      else if (busy) busy_cycles++;
      if (lat == 1) check({tag, "_hold"}, product, last_product);
      if (inject && lat == 1) begin
        start = 1'b1;
        A = 32'd9;
        B = 32'd9;
      end
      if (inject && lat == 2) start = 1'b0;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_lat"}, PW'(lat), PW'(W + 1));
    check({tag, "_busy_cycles"}, PW'(busy_cycles), PW'(W));
    check({tag, "_busy_in_done"}, PW'(busy), '0);
    check({tag, "_product"}, product, exp);
    last_product = exp;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_done_low"}, PW'(done), '0);
    check({tag, "_busy_low"}, PW'(busy), '0);
    check({tag, "_product_held"}, product, last_product);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    A = '0;
    B = '0;
    last_product = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", PW'(busy), '0);
    check("reset_done", PW'(done), '0);
    check("reset_product", product, '0);
    reset = 1'b0;

    // Basic and max operands
    launch(32'd3, 32'd5, 1'b0, 0);
    wait_done("basic", 0);
    check("basic_const", product, 64'h0000_0000_0000_000F);
    expect_idle("basic");

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    wait_done("max", 0);
    check("max_const", product, 64'hFFFF_FFFE_0000_0001);
    expect_idle("max");

    // Start while busy must be ignored
    launch(32'd2, 32'd4, 1'b0, 0);
    wait_done("busyprot", 1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("busyprot_extra_pulses", PW'(pulses), '0);
    check("busyprot_const", product, 64'd8);

    // Back-to-back: restart in the DONE cycle
    launch(32'd6, 32'd7, 1'b0, 0);
    wait_done("b2b_first", 0);
    launch(32'd10, 32'd10, 1'b0, 1);
    wait_done("b2b_second", 0);
    check("b2b_const", product, 64'd100);
    expect_idle("b2b");

    // Signed-op cases (model decides per build whether signed_op matters)
    launch(32'hFFFF_FFFD, 32'd7, 1'b1, 0);
    wait_done("sgn_neg3x7", 0);
    expect_idle("sgn_neg3x7");
    launch(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    wait_done("sgn_minxmin", 0);
    expect_idle("sgn_minxmin");
    launch(32'hFFFF_FFFD, 32'd7, 1'b0, 0);
    wait_done("uns_neg3x7", 0);
    check("uns_neg3x7_const", product, 64'h0000_0006_FFFF_FFEB);
    expect_idle("uns_neg3x7");

    // Zero operand still takes the full latency
    launch(32'd0, 32'h1234_5678, 1'b0, 0);
    wait_done("zero", 0);
    expect_idle("zero");

    // Random operands, with occasional edge values and back-to-back restarts
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      launch(ra, rb, 1'($urandom_range(0, 1)), (i > 0) && ($urandom_range(0, 2) == 0));
      wait_done("rand", 0);
    end
    expect_idle("rand_tail");

    // Reset in the middle of an operation
    launch(32'd123, 32'd456, 1'b0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    last_product = '0;
    @(negedge clk);
    check("midreset_busy", PW'(busy), '0);
    check("midreset_done", PW'(done), '0);
    check("midreset_product", product, '0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midreset_no_done", PW'(pulses), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
